// File: rtl/hard_reset_receiver_pkg.sv
// Shared definitions for the protocol-layer hard-reset receive and transmit machines.
package hard_reset_receiver_pkg;

   localparam int unsigned STATE_W    = 5;
   localparam int unsigned ALERT_W    = 16;
   localparam int unsigned RD_W       = 8;
   localparam int unsigned HR_COUNT_W = 8;

   // One-hot receive machine states
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE        = 5'b00001,
      ST_RESET_LAYER = 5'b00010,
      ST_INDICATE    = 5'b00100,
      ST_WAIT_PE     = 5'b01000,
      ST_COMPLETE    = 5'b10000
   } hr_state_e;

   // ALERT register bit positions
   localparam int unsigned ALERT_RECEIVED_HARD_RESET = 3;
   localparam int unsigned ALERT_TRANSMIT_FAILED     = 4;
   localparam int unsigned ALERT_TRANSMIT_SUCCESS    = 6;

   // RECEIVE_DETECT register bit positions
   localparam int unsigned RD_HARD_RESET_EN  = 5;
   localparam int unsigned RD_CABLE_RESET_EN = 6;

   // TRANSMIT register reset type codes shared with the transmit machine
   localparam logic [2:0] TX_TYPE_HARD_RESET  = 3'b101;
   localparam logic [2:0] TX_TYPE_CABLE_RESET = 3'b110;

   // Reset type as reported on oRESET_TYPE
   typedef enum logic {
      RST_HARD  = 1'b0,
      RST_CABLE = 1'b1
   } reset_type_e;

   // Saturating increment for the accepted-reset counter
   function automatic logic [HR_COUNT_W-1:0] sat_inc(input logic [HR_COUNT_W-1:0] v);
      return (&v) ? v : v + HR_COUNT_W'(1);
   endfunction

endpackage

// File: rtl/hr_timeout_counter.sv
// Loadable up-counter with clear, enable and terminal-count flag.
module hr_timeout_counter #(
   parameter int unsigned CNT_W    = 10,
   parameter int unsigned TERMINAL = 899
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc_c
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear beats load beats increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_c = (cnt_q == CNT_W'(TERMINAL));

endmodule

// File: rtl/hard_reset_receiver.sv
// Hard/Cable Reset receive machine: resets the protocol layer, raises ALERT,
// tells the policy engine and stays busy until it reports completion.
// Optional bounded wait on the policy engine: define HR_COMPLETE_TIMEOUT_EN.
module hard_reset_receiver
   import hard_reset_receiver_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 900,
   parameter int unsigned CNT_W          = 10
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  iRX_HARD_RESET,
   input  logic                  iRX_CABLE_RESET,
   input  logic [RD_W-1:0]       iRECEIVE_DETECT,
   input  logic [ALERT_W-1:0]    iALERT_CLEAR,
   input  logic                  iPE_HR_COMPLETE,
   output logic [ALERT_W-1:0]    oALERT,
   output logic [RD_W-1:0]       oRECEIVE_DETECT,
   output logic                  oRECEIVE_DETECT_WE,
   output logic                  oPRL_RESET,
   output logic                  oHR_INDICATION,
   output logic                  oRESET_TYPE,
   output logic                  oHR_BUSY,
   output logic [HR_COUNT_W-1:0] oHR_COUNT,
   output logic                  oHR_TIMEOUT
);

   hr_state_e             state_q, state_d;
   logic                  prl_reset_q, prl_reset_d;
   logic                  rd_we_q, rd_we_d;
   logic                  indication_q, indication_d;
   logic                  alert_hr_q, alert_hr_d;
   logic                  reset_type_q, reset_type_d;
   logic                  busy_q, busy_d;
   logic [HR_COUNT_W-1:0] count_q, count_d;
   logic                  timeout_q, timeout_d;

   logic hr_evt_c;
   logic cr_evt_c;
   logic evt_c;
   logic timeout_c;

   // Only enabled detections count as events
   assign hr_evt_c = iRX_HARD_RESET  & iRECEIVE_DETECT[RD_HARD_RESET_EN];
   assign cr_evt_c = iRX_CABLE_RESET & iRECEIVE_DETECT[RD_CABLE_RESET_EN];
   assign evt_c    = hr_evt_c | cr_evt_c;

`ifdef HR_COMPLETE_TIMEOUT_EN
   logic cnt_clr_c;
   logic cnt_en_c;
   logic tc_c;

   assign cnt_clr_c = (state_q == ST_INDICATE);
   assign cnt_en_c  = (state_q == ST_WAIT_PE);

   hr_timeout_counter #(
      .CNT_W    (CNT_W),
      .TERMINAL (TIMEOUT_CYCLES - 1)
   ) u_timeout_cnt (
      .clk      (CLK),
      .rst_n    (reset),
      .clr      (cnt_clr_c),
      .en       (cnt_en_c),
      .load     (1'b0),
      .load_val ('0),
      .tc_c     (tc_c)
   );

   // Completion from the policy engine in the terminal cycle pre-empts the timeout
   assign timeout_c = (state_q == ST_WAIT_PE) & tc_c & ~iPE_HR_COMPLETE;
`else
   logic [CNT_W-1:0] unused_cfg_c;

   assign unused_cfg_c = CNT_W'(TIMEOUT_CYCLES);
   assign timeout_c    = 1'b0;
`endif

   // Next state: a qualified event restarts the sequence from any state
   always_comb begin
      state_d = state_q;
      if (evt_c) begin
         state_d = ST_RESET_LAYER;
      end else begin
         unique case (state_q)
            ST_IDLE:        state_d = ST_IDLE;
            ST_RESET_LAYER: state_d = ST_INDICATE;
            ST_INDICATE:    state_d = ST_WAIT_PE;
            ST_WAIT_PE:     if (iPE_HR_COMPLETE || timeout_c) state_d = ST_COMPLETE;
            ST_COMPLETE:    state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
         endcase
      end
   end

   // Output and status next values; pulses decode the upcoming state so they register in step with it
   always_comb begin
      prl_reset_d  = (state_d == ST_RESET_LAYER);
      rd_we_d      = (state_d == ST_RESET_LAYER);
      indication_d = (state_d == ST_INDICATE);
      busy_d       = (state_d != ST_IDLE);
      alert_hr_d   = (state_q == ST_INDICATE) |
                     (alert_hr_q & ~iALERT_CLEAR[ALERT_RECEIVED_HARD_RESET]);
      reset_type_d = reset_type_q;
      count_d      = count_q;
      timeout_d    = timeout_q;
      if (evt_c) begin
         reset_type_d = hr_evt_c ? RST_HARD : RST_CABLE;
         count_d      = sat_inc(count_q);
         timeout_d    = 1'b0;
      end else if (timeout_c) begin
         timeout_d    = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         prl_reset_q  <= 1'b0;
         rd_we_q      <= 1'b0;
         indication_q <= 1'b0;
         alert_hr_q   <= 1'b0;
         reset_type_q <= 1'b0;
         busy_q       <= 1'b0;
         count_q      <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         prl_reset_q  <= prl_reset_d;
         rd_we_q      <= rd_we_d;
         indication_q <= indication_d;
         alert_hr_q   <= alert_hr_d;
         reset_type_q <= reset_type_d;
         busy_q       <= busy_d;
         count_q      <= count_d;
         timeout_q    <= timeout_d;
      end
   end

   logic unused_in_c;
   assign unused_in_c = ^{iALERT_CLEAR[15:4], iALERT_CLEAR[2:0],
                          iRECEIVE_DETECT[7], iRECEIVE_DETECT[4:0]};

   assign oALERT             = ALERT_W'(alert_hr_q) << ALERT_RECEIVED_HARD_RESET;
   assign oRECEIVE_DETECT    = '0;
   assign oRECEIVE_DETECT_WE = rd_we_q;
   assign oPRL_RESET         = prl_reset_q;
   assign oHR_INDICATION     = indication_q;
   assign oRESET_TYPE        = reset_type_q;
   assign oHR_BUSY           = busy_q;
   assign oHR_COUNT          = count_q;
   assign oHR_TIMEOUT        = timeout_q;

endmodule

// File: doc/hard_reset_receiver.md
Name: hard_reset_receiver

Overview:
- Receive-side counterpart of the protocol-layer Hard Reset transmit machine.
- Accepts Hard Reset or Cable Reset ordered-set detections from the PHY, gated by the RECEIVE_DETECT enables.
- Resets the protocol layer, clears RECEIVE_DETECT, raises ALERT.ReceivedHardReset and indicates the event to the policy engine.
- Holds the layer busy until the policy engine reports completion; the wait can optionally be bounded by a timeout.

Parameters:
- TIMEOUT_CYCLES, 900: CLK cycles allowed in WAIT_PE before a forced completion (used only with the optional feature).
- CNT_W, 10: width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- iRX_HARD_RESET  in  1  one-cycle pulse: PHY detected Hard Reset ordered set.
- iRX_CABLE_RESET  in  1  one-cycle pulse: PHY detected Cable Reset ordered set.
- iRECEIVE_DETECT  in  8  current RECEIVE_DETECT register; bit5 = HardReset enable, bit6 = CableReset enable.
- iALERT_CLEAR  in  16  host write-1-to-clear strobe for ALERT.
- iPE_HR_COMPLETE  in  1  policy engine finished hard-reset processing; level or pulse.
- oALERT  out  16  ALERT contribution; only bit3 (ReceivedHardReset) is ever driven high.
- oRECEIVE_DETECT  out  8  value to write into RECEIVE_DETECT; always 8'h00.
- oRECEIVE_DETECT_WE  out  1  one-cycle write strobe for oRECEIVE_DETECT.
- oPRL_RESET  out  1  one-cycle reset to the other protocol-layer blocks (MessageID counters, retry counters).
- oHR_INDICATION  out  1  one-cycle pulse to the policy engine.
- oRESET_TYPE  out  1  0 = Hard Reset, 1 = Cable Reset; latched at acceptance.
- oHR_BUSY  out  1  high whenever state is not IDLE.
- oHR_COUNT  out  8  number of accepted resets; saturates at 255.
- oHR_TIMEOUT  out  1  sticky flag: last wait ended by timeout.

Behaviour:
- Reset (reset = 0): state IDLE; every output 0; timeout counter 0; internal type latch 0.
- Event qualification:
  - hr_evt = iRX_HARD_RESET & iRECEIVE_DETECT[5].
  - cr_evt = iRX_CABLE_RESET & iRECEIVE_DETECT[6].
  - evt = hr_evt | cr_evt.
  - If both are present in the same cycle, Hard Reset wins: oRESET_TYPE = 0.
  - Unqualified pulses are ignored with no side effects.
- One-hot states: IDLE, RESET_LAYER, INDICATE, WAIT_PE, COMPLETE.
- IDLE:
  - On evt: go to RESET_LAYER, latch oRESET_TYPE, increment oHR_COUNT (saturating), clear oHR_TIMEOUT.
- RESET_LAYER (1 cycle):
  - oPRL_RESET = 1 and oRECEIVE_DETECT_WE = 1 with oRECEIVE_DETECT = 0.
  - Go to INDICATE.
- INDICATE (1 cycle):
  - oHR_INDICATION = 1.
  - Set ALERT[3] on the next edge.
  - Clear the timeout counter.
  - Go to WAIT_PE.
- WAIT_PE:
  - Counter increments each cycle.
  - If iPE_HR_COMPLETE: go to COMPLETE.
  - Otherwise stay in WAIT_PE (see Optional Feature for timeout).
- COMPLETE (1 cycle): go to IDLE.
- Latency: evt at edge N gives oPRL_RESET during cycle N+1, oHR_INDICATION during N+2, and ALERT[3] visible from N+3.
- Restart: a qualified evt in any non-IDLE state forces RESET_LAYER on the next edge. The type is re-latched and the count increments again. Restart takes priority over iPE_HR_COMPLETE and over timeout.
- ALERT rules:
  - ALERT[3] is sticky.
  - Cleared by iALERT_CLEAR[3] = 1.
  - If set and clear occur in the same cycle, set wins.
  - All other ALERT bits are constant 0.
- oHR_BUSY is a registered decode of state != IDLE.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at 0; no pending pulse is emitted after reset deasserts.

Optional Feature:
- Macro: HR_COMPLETE_TIMEOUT_EN.
- Defined:
  - In WAIT_PE, when the counter equals TIMEOUT_CYCLES-1 and iPE_HR_COMPLETE = 0, go to COMPLETE and set oHR_TIMEOUT.
  - iPE_HR_COMPLETE in that same cycle wins, and oHR_TIMEOUT stays 0.
- Undefined:
  - WAIT_PE waits indefinitely.
  - The counter is removed and oHR_TIMEOUT is tied to 0.

Decomposition:
- Shared package holds:
  - state one-hot localparams;
  - ALERT bit indices: RECEIVED_HARD_RESET = 3, TRANSMIT_SUCCESS = 6, TRANSMIT_FAILED = 4;
  - RECEIVE_DETECT bit indices: HARD_RESET_EN = 5, CABLE_RESET_EN = 6;
  - the TRANSMIT reset type codes shared with the transmit machine.
- One sub-module: hr_timeout_counter.
  - Loadable CNT_W-bit up-counter with clear, enable and terminal-count output.
  - Instantiated only under HR_COMPLETE_TIMEOUT_EN.

Test Plan:
- Basic Hard Reset: iRECEIVE_DETECT = 8'h20, pulse iRX_HARD_RESET → oPRL_RESET at +1, oRECEIVE_DETECT_WE with 8'h00 at +1, oHR_INDICATION at +2, oALERT = 16'h0008 from +3, oRESET_TYPE = 0, oHR_COUNT = 1. Then iPE_HR_COMPLETE → oHR_BUSY low 2 cycles later.
- Gating: iRECEIVE_DETECT = 8'h00, pulse both detect inputs → no output change, state stays IDLE, oHR_COUNT = 0.
- Simultaneous and cable-only: detect = 8'h60, both pulses in the same cycle → oRESET_TYPE = 0. Then cable-only with detect = 8'h40 → oRESET_TYPE = 1, ALERT[3] = 1.
- ALERT clear race: hold iALERT_CLEAR = 16'h0008 during the INDICATE→WAIT_PE edge → ALERT[3] = 1. A later clear alone → ALERT[3] = 0.
- Restart and saturation: second qualified Hard Reset while in WAIT_PE → RESET_LAYER next cycle and oHR_COUNT increments. Accept 300 resets → oHR_COUNT = 255.
- Timeout (HR_COMPLETE_TIMEOUT_EN, TIMEOUT_CYCLES = 16): no iPE_HR_COMPLETE → COMPLETE after 16 WAIT_PE cycles with oHR_TIMEOUT = 1. Assert reset mid-WAIT_PE → all outputs 0 immediately.
